// File: rtl/seg_scan_capture.sv
// Receive-side monitor for the multiplexed seven-segment bus: captures each digit once stable
// and presents complete frames on a valid/ready interface. Optional: SEG_SCAN_DECODE_EN adds frame_char.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 7,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   trans_in,
    input  logic [6:0]              seg_in,
    output logic [NUM_DIGITS*7-1:0] frame_seg,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun,
    output logic                    sel_err
`ifdef SEG_SCAN_DECODE_EN
    ,
    output logic [NUM_DIGITS*7-1:0] frame_char
`endif
);

    localparam int                SEG_W      = 7;
    localparam int                FRAME_W    = NUM_DIGITS * SEG_W;
    localparam logic [15:0]       SETTLE_MAX = 16'(SETTLE_CYCLES);
    localparam logic [15:0]       SETTLE_M1  = 16'(SETTLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

    logic [NUM_DIGITS-1:0] trans_s1, trans_s2, trans_prev;
    logic [SEG_W-1:0]      seg_s1, seg_s2, seg_prev;
    logic [15:0]           settle_cnt;
    logic                  armed;
    logic [NUM_DIGITS-1:0] seen;
    logic [FRAME_W-1:0]    shadow;

    logic                  bus_changed, sample, capture, illegal, frame_done;
    logic [NUM_DIGITS-1:0] sel_low, digit_hit, seen_next, blank_next;
    logic [FRAME_W-1:0]    shadow_next;

    // The collector's COMPLETE state is transient: it is entered and left within the
    // completion cycle, so it reduces to the frame_done strobe below.
    always_comb begin
        bus_changed = (trans_s2 != trans_prev) || (seg_s2 != seg_prev);
        sample      = armed && !bus_changed && (settle_cnt == SETTLE_M1);
        sel_low     = ~trans_s2;
        for (int i = 0; i < NUM_DIGITS; i++) digit_hit[i] = sel_low[NUM_DIGITS-1-i];
        capture     = sample && $onehot(sel_low);
        illegal     = sample && (sel_low != '0) && !$onehot(sel_low);
        // NOTE: defaults first so every path assigns every output; no latches are inferred.
        shadow_next = shadow;
        seen_next   = seen;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (digit_hit[i]) shadow_next[i*SEG_W +: SEG_W] = seg_s2;
            seen_next = seen | digit_hit;
        end
        frame_done = capture && (seen_next == ALL_SEEN);
        for (int i = 0; i < NUM_DIGITS; i++)
            blank_next[i] = (shadow_next[i*SEG_W +: SEG_W] == {SEG_W{1'b1}});
    end

    // NOTE: the shadow registers are small and reset explicitly, so a partial frame can never
    // leak past a reset; sequential state is assigned with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans_s1    <= '1;
            trans_s2    <= '1;
            trans_prev  <= '1;
            seg_s1      <= '1;
            seg_s2      <= '1;
            seg_prev    <= '1;
            settle_cnt  <= '0;
            armed       <= 1'b1;
            seen        <= '0;
            shadow      <= '1;
            frame_seg   <= '1;
            frame_blank <= '1;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            trans_s1   <= trans_in;
            trans_s2   <= trans_s1;
            trans_prev <= trans_s2;
            seg_s1     <= seg_in;
            seg_s2     <= seg_s1;
            seg_prev   <= seg_s2;

            if (bus_changed) begin
                settle_cnt <= '0;
                armed      <= 1'b1;
            end else begin
                if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 16'd1;
                if (sample) armed <= 1'b0;
            end

            sel_err <= illegal;
            overrun <= 1'b0;
            shadow  <= shadow_next;
            seen    <= (illegal || frame_done) ? '0 : seen_next;

            if (frame_done) begin
                if (!frame_valid || frame_ready) begin
                    frame_seg   <= shadow_next;
                    frame_blank <= blank_next;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

`ifdef SEG_SCAN_DECODE_EN
    function automatic logic [6:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'h40: return 7'd0;   7'h79: return 7'd1;
            7'h24: return 7'd2;   7'h30: return 7'd3;
            7'h19: return 7'd4;   7'h12: return 7'd5;
            7'h02: return 7'd6;   7'h78: return 7'd7;
            7'h00: return 7'd8;   7'h10: return 7'd9;
            7'h08: return 7'd10;  7'h03: return 7'd11;
            7'h46: return 7'd12;  7'h21: return 7'd13;
            7'h06: return 7'd14;  7'h0E: return 7'd15;
            7'h7F: return 7'h7F;
            default: return 7'h7E;
        endcase
    endfunction

    logic [FRAME_W-1:0] char_next;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            char_next[i*SEG_W +: SEG_W] = decode_glyph(shadow_next[i*SEG_W +: SEG_W]);
    end

    // Loaded under exactly the same condition as frame_seg so the two stay in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_char <= '1;
        else if (frame_done && (!frame_valid || frame_ready)) frame_char <= char_next;
    end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scan, glitch, overwrite, illegal select,
// backpressure and reset/blanking scenarios with hand-computed frames.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  trans_in, seg_in;
    logic [48:0] frame_seg;
    logic [6:0]  frame_blank;
    logic        frame_valid, frame_ready, overrun, sel_err;
`ifdef SEG_SCAN_DECODE_EN
    logic [48:0] frame_char;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;
    int n_overrun = 0;
    int n_sel_err = 0;

    // Digit 6 .. digit 0, most significant field first.
    logic [48:0] ref_f   = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [48:0] alt_f   = {7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    logic [48:0] glit_f  = {7'h06, 7'h21, 7'h46, 7'h03, 7'h24, 7'h10, 7'h00};
    logic [48:0] ovw_f   = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F};
    logic [48:0] mix_f   = {7'h02, 7'h12, 7'h19, 7'h03, 7'h08, 7'h10, 7'h00};
    logic [48:0] blank_f = {49{1'b1}};
    logic [48:0] blk_seg = {7{7'h7F}};

    seg_scan_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trans_in    (trans_in),
        .seg_in      (seg_in),
        .frame_seg   (frame_seg),
        .frame_blank (frame_blank),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .sel_err     (sel_err)
`ifdef SEG_SCAN_DECODE_EN
        ,
        .frame_char  (frame_char)
`endif
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle; a handshake is counted the cycle it is offered.
    always @(negedge clk) begin
        if (frame_valid && frame_ready) n_frames++;
        if (overrun) n_overrun++;
        if (sel_err) n_sel_err++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] sel(input int d);
        logic [6:0] v;
        v = 7'h7F;
        v[6-d] = 1'b0;
        return v;
    endfunction

    task automatic hold(input logic [6:0] t, input logic [6:0] s, input int n);
        trans_in = t;
        seg_in   = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [48:0] f, input int lo, input int hi);
        for (int d = lo; d <= hi; d++) hold(sel(d), f[7*d +: 7], 20);
    endtask

    initial begin
        int base_f, base_o, base_s;

        rst_n = 1'b0;
        frame_ready = 1'b1;
        trans_in = 7'h7F;
        seg_in = 7'h7F;

        // Reset with random bus activity.
        repeat (6) begin
            @(posedge clk); #1;
            trans_in = 7'($urandom);
            seg_in   = 7'($urandom);
        end
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_seg",   64'(frame_seg), 64'(blank_f));
        check("rst_blank", 64'(frame_blank), 64'h7F);
        check("rst_pulses", 64'(overrun | sel_err), 64'd0);
        trans_in = 7'h7F;
        seg_in   = 7'h7F;
        rst_n    = 1'b1;
        hold(7'h7F, 7'h7F, 20);
        check("post_rst_valid", 64'(frame_valid), 64'd0);
        check("post_rst_frames", 64'(n_frames), 64'd0);

        // Basic scan with latency check on the last digit.
        base_f = n_frames;
        scan(ref_f, 0, 5);
        hold(sel(6), 7'h02, 18);
        check("lat_not_yet", 64'(frame_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_valid", 64'(frame_valid), 64'd1);
        check("scan_d0", 64'(frame_seg[6:0]), 64'h40);
        check("scan_d6", 64'(frame_seg[48:42]), 64'h02);
        check("scan_frame", 64'(frame_seg), 64'(ref_f));
        check("scan_blank", 64'(frame_blank), 64'h00);
`ifdef SEG_SCAN_DECODE_EN
        check("scan_char", 64'(frame_char),
              64'({7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0}));
`endif
        @(posedge clk); #1;
        check("scan_consumed", 64'(frame_valid), 64'd0);
        check("scan_count", 64'(n_frames - base_f), 64'd1);
        check("scan_overrun", 64'(n_overrun), 64'd0);

        // Glitching digit 2 plus an inter-digit blanking interval.
        base_f = n_frames;
        hold(sel(0), 7'h00, 20);
        hold(sel(1), 7'h10, 20);
        for (int k = 0; k < 10; k++) hold(sel(2), (k % 2 == 1) ? 7'h46 : 7'h08, 10);
        hold(sel(2), 7'h24, 20);
        hold(sel(3), 7'h03, 20);
        hold(sel(4), 7'h46, 20);
        hold(7'h7F, 7'h7F, 20);
        hold(sel(5), 7'h21, 20);
        hold(sel(6), 7'h06, 20);
        check("glitch_count", 64'(n_frames - base_f), 64'd1);
        check("glitch_frame", 64'(frame_seg), 64'(glit_f));
        check("glitch_sel_err", 64'(n_sel_err), 64'd0);

        // Re-scanning an already seen digit overwrites it.
        base_f = n_frames;
        scan(ref_f, 0, 5);
        hold(sel(0), 7'h7F, 20);
        hold(sel(6), 7'h02, 20);
        check("ovw_count", 64'(n_frames - base_f), 64'd1);
        check("ovw_frame", 64'(frame_seg), 64'(ovw_f));
        check("ovw_blank", 64'(frame_blank), 64'h01);

        // Illegal select mid-frame discards digits collected so far.
        base_f = n_frames;
        base_s = n_sel_err;
        scan(ref_f, 0, 3);
        hold(7'b0011111, 7'h00, 20);
        check("ill_sel_err", 64'(n_sel_err - base_s), 64'd1);
        scan(ref_f, 4, 6);
        check("ill_no_frame", 64'(n_frames - base_f), 64'd0);
        scan(alt_f, 0, 3);
        check("ill_recover_count", 64'(n_frames - base_f), 64'd1);
        check("ill_recover_frame", 64'(frame_seg), 64'(mix_f));
        check("ill_sel_err_once", 64'(n_sel_err - base_s), 64'd1);

        // Backpressure: second frame dropped while the first is pending.
        base_f = n_frames;
        base_o = n_overrun;
        frame_ready = 1'b0;
        scan(alt_f, 0, 6);
        check("bp_valid1", 64'(frame_valid), 64'd1);
        check("bp_frame1", 64'(frame_seg), 64'(alt_f));
        check("bp_no_overrun", 64'(n_overrun - base_o), 64'd0);
        scan(ref_f, 0, 6);
        check("bp_valid2", 64'(frame_valid), 64'd1);
        check("bp_frame_kept", 64'(frame_seg), 64'(alt_f));
        check("bp_overrun", 64'(n_overrun - base_o), 64'd1);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 64'(frame_valid), 64'd0);
        check("bp_count", 64'(n_frames - base_f), 64'd1);
        check("bp_frame_after", 64'(frame_seg), 64'(alt_f));

        // Reset mid-frame, then an all-blank frame.
        base_f = n_frames;
        scan(ref_f, 0, 3);
        rst_n = 1'b0;
        hold(7'h7F, 7'h7F, 5);
        check("mid_rst_valid", 64'(frame_valid), 64'd0);
        check("mid_rst_seg", 64'(frame_seg), 64'(blank_f));
        check("mid_rst_blank", 64'(frame_blank), 64'h7F);
        rst_n = 1'b1;
        hold(7'h7F, 7'h7F, 20);
        scan(blk_seg, 4, 6);
        check("blk_partial", 64'(n_frames - base_f), 64'd0);
        scan(blk_seg, 0, 3);
        check("blk_count", 64'(n_frames - base_f), 64'd1);
        check("blk_blank", 64'(frame_blank), 64'h7F);
        check("blk_seg", 64'(frame_seg), 64'(blank_f));
`ifdef SEG_SCAN_DECODE_EN
        check("blk_char", 64'(frame_char), 64'(blank_f));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
